icache_top: RTL
===============

# icache_top

Instruction-cache responder for the fetch stage: accepts fetch requests carrying a PC and returns the addressed instruction. Hits complete in one cycle; misses refill a whole line from the memory side. Direct-mapped, with tag/data arrays and valid bits held in flops. Sits between `fetch_top` and the memory/bus layer, on the icache end of the ICacheFetch protocol.

## Interface
Parameters:
- `ADDR`, `AddrWidth`: address width.
- `INST`, `InstWidth`: instruction/word width.
- `LINE_WORDS`, 4: words per line, power of 2.
- `SETS`, 64: number of lines, power of 2.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset_` in 1: asynchronous, active-low reset.
- `ic_req_en` in 1: fetch request valid.
- `ic_pc` in ADDR: fetch address; bits [1:0] are ignored.
- `ic_flush` in 1: invalidate all lines.
- `ic_busy` out 1: registered; high means requests are ignored.
- `ic_inst_valid` out 1: registered; `ic_inst` valid this cycle.
- `ic_inst` out INST: registered instruction.
- `mem_req` out 1: line-fill request.
- `mem_addr` out ADDR: line-aligned fill address.
- `mem_ready` in 1: memory accepts the request (handshake with `mem_req`).
- `mem_rvalid` in 1: one fill beat this cycle.
- `mem_rdata` in INST: fill beat data.

## Operation
- Address split: offset = `log2(LINE_WORDS)+2` bits, index = next `log2(SETS)` bits, tag = the remainder. Defaults: word = [3:2], index = [9:4], tag = [31:10].
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - `ic_req_en` with `ic_busy=0` is looked up combinationally.
  - Hit: `ic_inst_valid=1` next cycle with the word; state stays IDLE.
  - Miss: PC is captured into `miss_pc`; next state is REQ.
- REQ:
  - `mem_req=1`; `mem_addr = {miss_pc[ADDR-1:offset], 0}`. Both are held stable until `mem_ready=1`.
  - The cycle `mem_ready=1` is seen: next state is FILL, beat counter = 0.
  - `mem_req` deasserts in FILL.
- FILL:
  - Each `mem_rvalid` writes `mem_rdata` to word[counter] of the indexed line, then counter++.
  - Gaps between beats are legal.
  - On beat `LINE_WORDS-1`: the tag is written, the valid bit is set (unless a flush is pending), and next state is IDLE.
  - The requested word is returned in the following cycle; a same-cycle last beat is bypassed into the output.
- `ic_busy = (state != IDLE)`. Requests while busy are dropped; fetch re-presents them.
- `mem_rvalid` is ignored in IDLE and REQ.
- Flush:
  - In IDLE, `ic_flush` clears all valid bits at the edge. A same-cycle `ic_req_en` is treated as a miss.
  - In REQ/FILL, flush sets `flush_pend`. The fill still completes and responds, but the valid bit is not set. `flush_pend` clears on return to IDLE, and all valid bits are cleared at that point.
- Reset (asynchronous, any state, including mid-fill):
  - state = IDLE, all valid bits = 0, counter = 0, `flush_pend` = 0.
  - `ic_busy=0`, `ic_inst_valid=0`, `ic_inst=0`, `mem_req=0`, `mem_addr=0`.
  - Data and tag arrays are not reset.

## Timing
- Hit: request in cycle N → `ic_inst_valid` in N+1. Back-to-back hits sustain 1 instruction per cycle.
- Miss: request in N → `ic_busy=1` and `mem_req=1` from N+1.
  - Accepted at cycle A → FILL from A+1.
  - Last beat at L → `ic_inst_valid=1` and `ic_busy=0` at L+1.
  - A new request may be issued at L+1.
- `ic_inst_valid` is a one-cycle pulse per accepted request. `ic_inst` holds its last value otherwise.

## Structure
- Shared package `icache_pkg`:
  - `IcState_t` enum (IDLE/REQ/FILL).
  - Width constants derived from ADDR/LINE_WORDS/SETS: `IC_OFS`, `IC_IDX`, `IC_TAG`.
- One sub-module, `ic_line_array`: tag + data storage with asynchronous read and synchronous word/tag write. Valid bits stay in `icache_top`.

## Test plan
- Reset, then request `ic_pc=0x0000_1004` → `mem_req` with `mem_addr=0x0000_1000` at N+1. After `mem_ready`, beats 0x11, 0x22, 0x33, 0x44 → `ic_inst=0x22`, `ic_inst_valid=1` one cycle after the 4th beat.
- Then request 0x0000_100C → hit: `ic_inst=0x44` next cycle, no `mem_req`, `ic_busy` stays 0. Back-to-back 0x1000/0x1008 → 0x11, 0x33 on consecutive cycles.
- Conflict: request 0x0000_1404 (index 0, new tag) → miss and refill with 0xA0..0xA3 → 0xA1. Then 0x1004 misses again.
- `mem_ready` delayed 5 cycles and beats with 2-cycle gaps → `mem_addr`/`mem_req` stable throughout. Requests while busy are ignored. Response arrives at last beat + 1.
- Flush: `ic_flush` in IDLE, then 0x100C → miss. Flush after beat 2 of a fill → response still delivered; re-request of the same PC misses.
- `reset_` low mid-FILL → all outputs 0 immediately. Stray `mem_rvalid` afterward is ignored. Re-request of the same line misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
//   IcState_t          : controller states (IDLE / REQ / FILL)
//   IC_OFS/IC_IDX/IC_TAG : address field widths for the default geometry
//   ic_ofs_w/ic_idx_w  : field widths for any power-of-two geometry
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } IcState_t;

    localparam int IC_ADDR       = 32;
    localparam int IC_INST       = 32;
    localparam int IC_LINE_WORDS = 4;
    localparam int IC_SETS       = 64;

    // Byte offset inside a line: word select plus the two byte bits.
    function automatic int ic_ofs_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int ic_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    localparam int IC_OFS = ic_ofs_w(IC_LINE_WORDS);
    localparam int IC_IDX = ic_idx_w(IC_SETS);
    localparam int IC_TAG = IC_ADDR - IC_OFS - IC_IDX;

endpackage

// File: rtl/ic_line_array.sv
// Tag and data storage for the direct-mapped instruction cache.
// Reads are asynchronous; word and tag writes happen on the rising edge.
// Ports:
//   clk              : clock
//   word_we          : write wr_data into word wr_word of line wr_idx
//   tag_we           : write wr_tag into the tag of line wr_idx
//   wr_idx/wr_word   : write location
//   wr_data/wr_tag   : write values
//   rd_idx/rd_word   : read location
//   rd_data/rd_tag   : word and tag at the read location
module ic_line_array
    import icache_pkg::*;
#(
    parameter int INST       = IC_INST,
    parameter int TAG        = IC_TAG,
    parameter int LINE_WORDS = IC_LINE_WORDS,
    parameter int SETS       = IC_SETS
) (
    input  logic                          clk,
    input  logic                          word_we,
    input  logic                          tag_we,
    input  logic [$clog2(SETS)-1:0]       wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
    input  logic [INST-1:0]               wr_data,
    input  logic [TAG-1:0]                wr_tag,
    input  logic [$clog2(SETS)-1:0]       rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
    output logic [INST-1:0]               rd_data,
    output logic [TAG-1:0]                rd_tag
);

    logic [INST-1:0] data_mem [SETS][LINE_WORDS];
    logic [TAG-1:0]  tag_mem  [SETS];

    // NOTE: the arrays carry no reset; the valid bits in the parent are what
    // make stale contents harmless, and leaving them out keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (word_we) data_mem[wr_idx][wr_word] <= wr_data;
        if (tag_we)  tag_mem[wr_idx]           <= wr_tag;
    end

    assign rd_data = data_mem[rd_idx][rd_word];
    assign rd_tag  = tag_mem[rd_idx];

endmodule

// File: rtl/icache_top.sv
// Direct-mapped instruction cache answering fetch requests.
// Hits return the word one cycle after the request; misses fetch the whole
// line from memory (one request handshake, then LINE_WORDS beats).
// Ports:
//   clk, reset_                 : clock, asynchronous active-low reset
//   ic_req_en, ic_pc            : fetch request and address (bits [1:0] ignored)
//   ic_flush                    : invalidate every line
//   ic_busy                     : requests are dropped while high
//   ic_inst_valid, ic_inst      : registered response pulse and instruction
//   mem_req, mem_addr, mem_ready: line-fill request handshake
//   mem_rvalid, mem_rdata       : fill beats
module icache_top
    import icache_pkg::*;
#(
    parameter int ADDR       = IC_ADDR,
    parameter int INST       = IC_INST,
    parameter int LINE_WORDS = IC_LINE_WORDS,
    parameter int SETS       = IC_SETS
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            ic_req_en,
    input  logic [ADDR-1:0] ic_pc,
    input  logic            ic_flush,
    output logic            ic_busy,
    output logic            ic_inst_valid,
    output logic [INST-1:0] ic_inst,
    output logic            mem_req,
    output logic [ADDR-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [INST-1:0] mem_rdata
);

    localparam int OFS = ic_ofs_w(LINE_WORDS);
    localparam int IDX = ic_idx_w(SETS);
    localparam int TAG = ADDR - OFS - IDX;
    localparam int WW  = OFS - 2;

    IcState_t        state, next_state;
    logic [ADDR-1:0] miss_pc;
    logic [WW-1:0]   cnt;
    logic            flush_pend;
    logic [SETS-1:0] valid;

    logic [WW-1:0]   pc_word, miss_word, rd_word;
    logic [IDX-1:0]  pc_idx, miss_idx, rd_idx;
    logic [TAG-1:0]  pc_tag, miss_tag, rd_tag;
    logic [INST-1:0] rd_data;
    logic            accept, hit, beat, last_beat, flush_now;
    logic            unused_byte_bits;

    assign pc_word   = ic_pc[OFS-1:2];
    assign pc_idx    = ic_pc[OFS+IDX-1:OFS];
    assign pc_tag    = ic_pc[ADDR-1:OFS+IDX];
    assign miss_word = miss_pc[OFS-1:2];
    assign miss_idx  = miss_pc[OFS+IDX-1:OFS];
    assign miss_tag  = miss_pc[ADDR-1:OFS+IDX];
    assign unused_byte_bits = ^{ic_pc[1:0], miss_pc[1:0]};

    // One read port: the lookup address while idle, the missed word while
    // filling (needed when the response word arrived before the last beat).
    assign rd_idx  = (state == IDLE) ? pc_idx  : miss_idx;
    assign rd_word = (state == IDLE) ? pc_word : miss_word;

    // A flush in the same cycle wipes the valid bits at this edge, so the
    // lookup must already count as a miss.
    assign accept    = (state == IDLE) && ic_req_en;
    assign hit       = accept && !ic_flush && valid[pc_idx] && (rd_tag == pc_tag);
    assign beat      = (state == FILL) && mem_rvalid;
    assign last_beat = beat && (cnt == WW'(LINE_WORDS - 1));
    assign flush_now = flush_pend || ic_flush;

    assign mem_req  = (state == REQ);
    assign mem_addr = mem_req ? {miss_pc[ADDR-1:OFS], {OFS{1'b0}}} : '0;

    ic_line_array #(
        .INST      (INST),
        .TAG       (TAG),
        .LINE_WORDS(LINE_WORDS),
        .SETS      (SETS)
    ) u_lines (
        .clk    (clk),
        .word_we(beat),
        .tag_we (last_beat),
        .wr_idx (miss_idx),
        .wr_word(cnt),
        .wr_data(mem_rdata),
        .wr_tag (miss_tag),
        .rd_idx (rd_idx),
        .rd_word(rd_word),
        .rd_data(rd_data),
        .rd_tag (rd_tag)
    );

    // NOTE: flops are written with <= so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= next_state;
    end

    // NOTE: next_state gets its default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !hit) next_state = REQ;
            REQ:     if (mem_ready)      next_state = FILL;
            FILL:    if (last_beat)      next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ic_busy       <= 1'b0;
            ic_inst_valid <= 1'b0;
            ic_inst       <= '0;
            miss_pc       <= '0;
            cnt           <= '0;
            flush_pend    <= 1'b0;
            valid         <= '0;
        end else begin
            ic_busy       <= (next_state != IDLE);
            ic_inst_valid <= 1'b0;

            if (hit) begin
                ic_inst_valid <= 1'b1;
                ic_inst       <= rd_data;
            end else if (accept) begin
                miss_pc <= ic_pc;
            end

            if ((state == IDLE) && ic_flush) valid <= '0;
            if ((state != IDLE) && ic_flush) flush_pend <= 1'b1;

            if ((state == REQ) && mem_ready) cnt <= '0;
            else if (beat)                   cnt <= cnt + 1'b1;

            if (last_beat) begin
                ic_inst_valid <= 1'b1;
                // The last beat is not in the array yet, so bypass it.
                ic_inst       <= (miss_word == WW'(LINE_WORDS - 1)) ? mem_rdata : rd_data;
                flush_pend    <= 1'b0;
                if (flush_now) valid <= '0;
                else           valid[miss_idx] <= 1'b1;
            end
        end
    end

endmodule
